// File: rtl/lsu_pkg.sv
// Shared types and byte-mask helper for the load/store sequencer.
// The two-access split is enabled by defining LSU_MISALIGNED_EN.
package lsu_pkg;

   typedef enum logic [1:0] {
      WORD = 2'b00,
      HALF = 2'b01,
      BYTE = 2'b10
   } lsu_type_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GNT1  = 3'd1,
      RVAL1 = 3'd2,
      GNT2  = 3'd3,
      RVAL2 = 3'd4
   } lsu_state_e;

   // Byte mask across two consecutive words; the encoding 11 behaves as a word.
   function automatic logic [7:0] lsu_mask(input logic [1:0] lsu_type, input logic [1:0] off);
      logic [7:0] base;
      case (lsu_type_e'(lsu_type))
         HALF:    base = 8'h03;
         BYTE:    base = 8'h01;
         default: base = 8'h0F;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment: byte enables, store-data rotation and load-data
// assembly/extension for the load/store sequencer.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  lsu_type,
   input  logic [1:0]  off,
   input  logic        sign_ext,
   input  logic        second,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_lo,
   input  logic [31:0] rdata_hi,
   output logic [3:0]  be,
   output logic        misaligned,
   output logic [31:0] wdata_rot,
   output logic [31:0] rdata
);

   logic [7:0]  mask;
   logic [5:0]  sh;
   logic [31:0] rdata_word;

   assign mask       = lsu_mask(lsu_type, off);
   assign be         = second ? mask[7:4] : mask[3:0];
   assign misaligned = |mask[7:4];
   assign sh         = {1'b0, off, 3'b000};

   // A shift by 32 yields zero, so off = 0 degenerates cleanly to a pass-through.
   assign wdata_rot  = (wdata << sh) | (wdata >> (6'd32 - sh));
   assign rdata_word = (rdata_lo >> sh) | (rdata_hi << (6'd32 - sh));

   always_comb begin
      rdata = rdata_word;
      case (lsu_type_e'(lsu_type))
         HALF:    rdata = {{16{sign_ext & rdata_word[15]}}, rdata_word[15:0]};
         BYTE:    rdata = {{24{sign_ext & rdata_word[7]}}, rdata_word[7:0]};
         default: rdata = rdata_word;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store request sequencer: req/gnt/rvalid handshake towards data memory.
// Define LSU_MISALIGNED_EN to split misaligned accesses into two word transactions.
module lsu_ctrl
   import lsu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [1:0]  lsu_type_i,
   input  logic        lsu_sign_ext_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        lsu_ready_o,
   output logic        lsu_rvalid_o,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_err_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic [31:0] data_rdata_i,
   input  logic        data_err_i
);

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic        sign_q;
   logic [1:0]  type_q;

   logic        accept;
   logic        complete;
   logic        err_d;
   logic        req;
   logic        second;
   logic [1:0]  cur_off;
   logic [1:0]  cur_type;
   logic [31:0] rd_lo;
   logic [31:0] rd_hi;
   logic [31:0] rdata_al;
   logic [31:0] rdata_d;
   logic [31:0] wdata_rot;
   logic [3:0]  be;
   logic        misaligned;
   logic [29:0] word_addr;
`ifdef LSU_MISALIGNED_EN
   logic        capture;
   logic [31:0] rdata1_q;
`endif

   // In IDLE the aligner looks at the incoming request so misalignment is known at accept time.
   assign cur_off  = (state_q == IDLE) ? lsu_addr_i[1:0] : addr_q[1:0];
   assign cur_type = (state_q == IDLE) ? lsu_type_i : type_q;

`ifdef LSU_MISALIGNED_EN
   assign second = (state_q == GNT2);
`else
   assign second = 1'b0;
`endif

   lsu_align u_align (
      .lsu_type   (cur_type),
      .off        (cur_off),
      .sign_ext   (sign_q),
      .second     (second),
      .wdata      (wdata_q),
      .rdata_lo   (rd_lo),
      .rdata_hi   (rd_hi),
      .be         (be),
      .misaligned (misaligned),
      .wdata_rot  (wdata_rot),
      .rdata      (rdata_al)
   );

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      complete = 1'b0;
      err_d    = 1'b0;
      req      = 1'b0;
      rd_lo    = data_rdata_i;
      rd_hi    = '0;
`ifdef LSU_MISALIGNED_EN
      capture  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (lsu_req_i) begin
               accept = 1'b1;
`ifdef LSU_MISALIGNED_EN
               state_d = GNT1;
`else
               if (misaligned) begin
                  complete = 1'b1;
                  err_d    = 1'b1;
               end else begin
                  state_d = GNT1;
               end
`endif
            end
         end
         GNT1: begin
            req = 1'b1;
            if (data_gnt_i) state_d = RVAL1;
         end
         RVAL1: begin
            if (data_rvalid_i) begin
`ifdef LSU_MISALIGNED_EN
               if (misaligned && !data_err_i) begin
                  capture = 1'b1;
                  state_d = GNT2;
               end else begin
                  complete = 1'b1;
                  err_d    = data_err_i;
                  state_d  = IDLE;
               end
`else
               complete = 1'b1;
               err_d    = data_err_i;
               state_d  = IDLE;
`endif
            end
         end
`ifdef LSU_MISALIGNED_EN
         GNT2: begin
            req = 1'b1;
            if (data_gnt_i) state_d = RVAL2;
         end
         RVAL2: begin
            rd_lo = rdata1_q;
            rd_hi = data_rdata_i;
            if (data_rvalid_i) begin
               complete = 1'b1;
               err_d    = data_err_i;
               state_d  = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign rdata_d = (err_d | we_q) ? '0 : rdata_al;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         lsu_rvalid_o <= 1'b0;
         lsu_err_o    <= 1'b0;
         lsu_rdata_o  <= '0;
      end else begin
         state_q      <= state_d;
         lsu_rvalid_o <= complete;
         lsu_err_o    <= err_d;
         if (complete) lsu_rdata_o <= rdata_d;
      end
   end

   // Request fields are pure data; memory-side outputs are gated by req so they need no reset.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         addr_q  <= lsu_addr_i;
         we_q    <= lsu_we_i;
         type_q  <= lsu_type_i;
         sign_q  <= lsu_sign_ext_i;
         wdata_q <= lsu_wdata_i;
      end
`ifdef LSU_MISALIGNED_EN
      if (capture) rdata1_q <= data_rdata_i;
`endif
   end

   assign lsu_ready_o  = (state_q == IDLE);
   assign word_addr    = second ? addr_q[31:2] + 30'd1 : addr_q[31:2];
   assign data_req_o   = req;
   assign data_addr_o  = req ? {word_addr, 2'b00} : '0;
   assign data_we_o    = req & we_q;
   assign data_be_o    = req ? be : '0;
   assign data_wdata_o = req ? wdata_rot : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl against a byte-level reference model.
// Follows LSU_MISALIGNED_EN the same way as the design.
module tb_lsu_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [1:0]  lsu_type_i;
   logic        lsu_sign_ext_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_ready_o;
   logic        lsu_rvalid_o;
   logic [31:0] lsu_rdata_o;
   logic        lsu_err_o;
   logic        data_req_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic [31:0] data_rdata_i;
   logic        data_err_i;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] last_rd  = '0;

   lsu_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .lsu_req_i      (lsu_req_i),
      .lsu_we_i       (lsu_we_i),
      .lsu_type_i     (lsu_type_i),
      .lsu_sign_ext_i (lsu_sign_ext_i),
      .lsu_addr_i     (lsu_addr_i),
      .lsu_wdata_i    (lsu_wdata_i),
      .lsu_ready_o    (lsu_ready_o),
      .lsu_rvalid_o   (lsu_rvalid_o),
      .lsu_rdata_o    (lsu_rdata_o),
      .lsu_err_o      (lsu_err_o),
      .data_req_o     (data_req_o),
      .data_gnt_i     (data_gnt_i),
      .data_rvalid_i  (data_rvalid_i),
      .data_addr_o    (data_addr_o),
      .data_we_o      (data_we_o),
      .data_be_o      (data_be_o),
      .data_wdata_o   (data_wdata_o),
      .data_rdata_i   (data_rdata_i),
      .data_err_i     (data_err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int size_of(input logic [1:0] typ);
      return (typ == 2'b01) ? 2 : (typ == 2'b10) ? 1 : 4;
   endfunction

   // Byte lanes of word k (0 = word holding addr, 1 = next word) touched by the access.
   function automatic logic [3:0] exp_be(input logic [31:0] addr, input int size, input int k);
      logic [3:0]  be;
      logic [31:0] a;
      logic [29:0] wk;
      be = '0;
      wk = addr[31:2] + 30'(k);
      for (int i = 0; i < size; i++) begin
         a = addr + 32'(i);
         if (a[31:2] == wk) be[a[1:0]] = 1'b1;
      end
      return be;
   endfunction

   // Lane L carries store byte (L - off) mod 4.
   function automatic logic [31:0] exp_wdata(input logic [31:0] wdata, input logic [1:0] off);
      logic [31:0] r;
      logic [1:0]  src;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         src = 2'(l) - off;
         r[8*l +: 8] = wdata[8*src +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] addr, input int size, input logic sext,
                                            input logic [31:0] w0, input logic [31:0] w1);
      logic [31:0] r;
      logic [31:0] a;
      logic [31:0] w;
      r = '0;
      for (int i = 0; i < size; i++) begin
         a = addr + 32'(i);
         w = (a[31:2] == addr[31:2]) ? w0 : w1;
         r[8*i +: 8] = w[8*a[1:0] +: 8];
      end
      if (sext && size == 1 && r[7])  r[31:8]  = '1;
      if (sext && size == 2 && r[15]) r[31:16] = '1;
      return r;
   endfunction

   task automatic do_access(input logic we, input logic [1:0] typ, input logic sext,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input logic err1, input logic err2, input int gdly, input int rdly);
      int          size;
      int          nw;
      logic [31:0] last;
      logic [31:0] exp_rd;
      logic        err;
      logic [29:0] wk;
      size = size_of(typ);
      last = addr + 32'(size - 1);
      nw   = (last[31:2] != addr[31:2]) ? 2 : 1;
      err  = 1'b0;

      check_eq("ready_idle", 32'(lsu_ready_o), 32'd1);
      lsu_req_i      = 1'b1;
      lsu_we_i       = we;
      lsu_type_i     = typ;
      lsu_sign_ext_i = sext;
      lsu_addr_i     = addr;
      lsu_wdata_i    = wdata;
      tick();
      lsu_req_i   = 1'b0;
      lsu_addr_i  = $urandom;
      lsu_wdata_i = $urandom;
      lsu_type_i  = 2'($urandom);

`ifndef LSU_MISALIGNED_EN
      if (nw == 2) begin
         check_eq("mis_rvalid", 32'(lsu_rvalid_o), 32'd1);
         check_eq("mis_err", 32'(lsu_err_o), 32'd1);
         check_eq("mis_rdata", lsu_rdata_o, 32'd0);
         check_eq("mis_noreq", 32'(data_req_o), 32'd0);
         last_rd = '0;
         tick();
         check_eq("mis_pulse_end", 32'(lsu_rvalid_o), 32'd0);
         return;
      end
`endif

      for (int k = 0; k < nw; k++) begin
         wk = addr[31:2] + 30'(k);
         check_eq("no_early_rvalid", 32'(lsu_rvalid_o), 32'd0);
         for (int c = 0; c <= gdly; c++) begin
            check_eq("req", 32'(data_req_o), 32'd1);
            check_eq("addr", data_addr_o, {wk, 2'b00});
            check_eq("be", 32'(data_be_o), 32'(exp_be(addr, size, k)));
            check_eq("we", 32'(data_we_o), 32'(we));
            check_eq("wdata", data_wdata_o, exp_wdata(wdata, addr[1:0]));
            if (c < gdly) tick();
         end
         data_gnt_i = 1'b1;
         tick();
         data_gnt_i = 1'b0;
         check_eq("req_after_gnt", 32'(data_req_o), 32'd0);
         for (int r = 0; r < rdly; r++) begin
            tick();
            check_eq("wait_rvalid", 32'(lsu_rvalid_o), 32'd0);
         end
         data_rvalid_i = 1'b1;
         data_rdata_i  = (k == 0) ? w0 : w1;
         data_err_i    = (k == 0) ? err1 : err2;
         err           = data_err_i;
         tick();
         data_rvalid_i = 1'b0;
         data_err_i    = 1'b0;
         data_rdata_i  = $urandom;
         if (err) break;
      end

      exp_rd = (err || we) ? 32'd0 : exp_load(addr, size, sext, w0, w1);
      check_eq("rvalid", 32'(lsu_rvalid_o), 32'd1);
      check_eq("err", 32'(lsu_err_o), 32'(err));
      check_eq("rdata", lsu_rdata_o, exp_rd);
      check_eq("no_more_req", 32'(data_req_o), 32'd0);
      last_rd = exp_rd;
      tick();
      check_eq("pulse_end", 32'(lsu_rvalid_o), 32'd0);
      check_eq("rdata_hold", lsu_rdata_o, last_rd);
   endtask

   initial begin
      rst_i          = 1'b1;
      lsu_req_i      = 1'b0;
      lsu_we_i       = 1'b0;
      lsu_type_i     = 2'b00;
      lsu_sign_ext_i = 1'b0;
      lsu_addr_i     = '0;
      lsu_wdata_i    = '0;
      data_gnt_i     = 1'b0;
      data_rvalid_i  = 1'b0;
      data_rdata_i   = '0;
      data_err_i     = 1'b0;
      tick();
      tick();
      check_eq("rst_ready", 32'(lsu_ready_o), 32'd1);
      check_eq("rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
      check_eq("rst_rdata", lsu_rdata_o, 32'd0);
      check_eq("rst_err", 32'(lsu_err_o), 32'd0);
      check_eq("rst_req", 32'(data_req_o), 32'd0);
      check_eq("rst_addr", data_addr_o, 32'd0);
      check_eq("rst_we", 32'(data_we_o), 32'd0);
      check_eq("rst_be", 32'(data_be_o), 32'd0);
      check_eq("rst_wdata", data_wdata_o, 32'd0);
      rst_i = 1'b0;
      tick();

      do_access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 0, 0);
      do_access(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 32'h80123456, 32'h0, 1'b0, 1'b0, 0, 1);
      do_access(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'h80123456, 32'h0, 1'b0, 1'b0, 1, 0);
      do_access(1'b1, 2'b00, 1'b0, 32'h102, 32'h11223344, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0);
      do_access(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hAABBCCDD, 32'h11223344, 1'b0, 1'b0, 0, 0);
      do_access(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 32'h12345678, 32'h0, 1'b0, 1'b0, 3, 0);
      do_access(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hAABBCCDD, 32'h11223344, 1'b1, 1'b0, 0, 0);
      do_access(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'h8001_0000, 32'h0, 1'b0, 1'b0, 0, 0);

      // Late memory response while idle must not produce a completion.
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'hCAFEF00D;
      tick();
      data_rvalid_i = 1'b0;
      check_eq("idle_rvalid_ignored", 32'(lsu_rvalid_o), 32'd0);
      check_eq("idle_rdata_hold", lsu_rdata_o, last_rd);

      // Reset while waiting for the first response.
      lsu_req_i  = 1'b1;
      lsu_we_i   = 1'b0;
      lsu_type_i = 2'b00;
      lsu_addr_i = 32'h400;
      tick();
      lsu_req_i  = 1'b0;
      data_gnt_i = 1'b1;
      tick();
      data_gnt_i = 1'b0;
      rst_i = 1'b1;
      #1;
      check_eq("midrst_ready", 32'(lsu_ready_o), 32'd1);
      check_eq("midrst_req", 32'(data_req_o), 32'd0);
      check_eq("midrst_rvalid", 32'(lsu_rvalid_o), 32'd0);
      check_eq("midrst_rdata", lsu_rdata_o, 32'd0);
      check_eq("midrst_addr", data_addr_o, 32'd0);
      check_eq("midrst_be", 32'(data_be_o), 32'd0);
      tick();
      rst_i = 1'b0;
      last_rd = '0;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h55AA55AA;
      tick();
      data_rvalid_i = 1'b0;
      check_eq("late_rvalid_ignored", 32'(lsu_rvalid_o), 32'd0);
      tick();
      check_eq("late_rvalid_ignored2", 32'(lsu_rvalid_o), 32'd0);
      check_eq("late_ready", 32'(lsu_ready_o), 32'd1);

      for (int t = 0; t < 80; t++) begin
         do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 3), $urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) begin
            data_rvalid_i = 1'b1;
            tick();
            data_rvalid_i = 1'b0;
            check_eq("rand_idle_rvalid", 32'(lsu_rvalid_o), 32'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store request sequencer sitting directly upstream of the LSU output capture stage.
- Accepts one load/store from execute and drives the data-memory req/gnt/rvalid handshake, splitting misaligned accesses into two word transactions.
- Aligns and sign/zero-extends read data.
- Its `lsu_rvalid_o` drives the capture enable of the downstream LSU output stage, and `lsu_rdata_o` is the value captured there.

## Interface
Parameters: none.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  asynchronous, active-high reset.
- `lsu_req_i`  in  1  request valid from execute.
- `lsu_we_i`  in  1  1 = store, 0 = load.
- `lsu_type_i`  in  2  00 word, 01 half, 10 byte; 11 is treated as word.
- `lsu_sign_ext_i`  in  1  sign-extend loaded half/byte.
- `lsu_addr_i`  in  32  byte address.
- `lsu_wdata_i`  in  32  store data, LSB-aligned.
- `lsu_ready_o`  out  1  block idle, request accepted this cycle.
- `lsu_rvalid_o`  out  1  one-cycle completion pulse; enable for the downstream capture stage.
- `lsu_rdata_o`  out  32  aligned, extended load data; 0 for stores.
- `lsu_err_o`  out  1  error qualifier, valid with `lsu_rvalid_o`.
- `data_req_o`  out  1  memory request.
- `data_gnt_i`  in  1  memory grant.
- `data_rvalid_i`  in  1  memory response valid.
- `data_addr_o`  out  32  word address; bits [1:0] are always 0.
- `data_we_o`  out  1  memory write enable.
- `data_be_o`  out  4  byte enables.
- `data_wdata_o`  out  32  rotated store data.
- `data_rdata_i`  in  32  memory read data.
- `data_err_i`  in  1  memory error, qualified by `data_rvalid_i`.

## Operation
- FSM states: IDLE, GNT1, RVAL1, GNT2, RVAL2. Only one transaction is outstanding at a time.
- IDLE:
  - `lsu_ready_o` = 1.
  - `lsu_req_i` = 1 registers addr, we, type, sign_ext and wdata, then goes to GNT1.
- GNT1 / GNT2:
  - `data_req_o` = 1.
  - `data_addr_o`, `data_we_o`, `data_be_o` and `data_wdata_o` are held stable until `data_gnt_i` = 1.
  - On grant, go to RVAL1 / RVAL2.
- RVAL1:
  - On `data_rvalid_i`, latch `data_rdata_i`.
  - If the access is misaligned and `data_err_i` = 0, go to GNT2; otherwise complete and return to IDLE.
- RVAL2: on `data_rvalid_i`, complete and return to IDLE.
- Alignment (off = addr[1:0]):
  - Base mask: word 1111, half 0011, byte 0001; 8-bit mask = base << off.
  - First access: addr = {addr[31:2], 00}, be = mask[3:0].
  - Second access: addr = {addr[31:2]+1, 00}, be = mask[7:4].
  - Misaligned means mask[7:4] ≠ 0.
  - `data_wdata_o` = `lsu_wdata_i` rotated left by 8·off, for both accesses.
- Read assembly:
  - Form the 64-bit value {rdata2, rdata1} and shift right by 8·off; take bits [31:0]. For aligned accesses rdata2 = 0.
  - Then truncate to the access size and extend per `lsu_sign_ext_i`.
- Error: `data_err_i` on the first response skips the second access. Completion reports `lsu_err_o` = 1 and `lsu_rdata_o` = 0.
- `data_rvalid_i` in IDLE, GNT1 or GNT2 is ignored.
- Stores complete on their final rvalid, the same as loads.

## Timing
- Reset values: state IDLE; `lsu_ready_o` 1; every other output 0, including all data_* outputs.
- Reset mid-operation: abandon the transaction immediately and return to IDLE with no completion pulse. A late memory response after reset is ignored.
- Request accepted at cycle N → `data_req_o` rises at N+1.
- Grant at cycle G → `data_req_o` is 0 at G+1.
- `lsu_rvalid_o`, `lsu_rdata_o` and `lsu_err_o` are registered. They assert in the cycle after the final `data_rvalid_i`, for exactly one cycle. `lsu_rdata_o` holds its value until the next completion.
- Minimum aligned latency: accept N, grant N+1, rvalid N+2, `lsu_rvalid_o` at N+3.
- `data_gnt_i` and `data_rvalid_i` in the same cycle is not permitted; rvalid follows gnt by at least one cycle.

## Configuration
- `LSU_MISALIGNED_EN` defined: misaligned accesses are split into two transactions as described above.
- `LSU_MISALIGNED_EN` undefined:
  - GNT2 and RVAL2 are not compiled.
  - A misaligned request issues no memory access.
  - It completes at N+1 with `lsu_rvalid_o` = 1, `lsu_err_o` = 1, `lsu_rdata_o` = 0.

## Structure
- `lsu_pkg`: `lsu_type_e` (WORD, HALF, BYTE) and `lsu_state_e`.
- Sub-module `lsu_align`, purely combinational: mask/be generation, wdata rotation, 64-bit read shift and extension.
- `lsu_ctrl` holds the FSM and all registers.

## Test plan
- Aligned word load, addr 0x100, rdata 0xDEADBEEF → `data_addr_o` 0x100, be 1111; `lsu_rdata_o` 0xDEADBEEF at rvalid+1.
- Signed byte load, addr 0x103, rdata 0x80123456 → be 1000; `lsu_rdata_o` 0xFFFFFF80. With sign_ext = 0 → 0x00000080.
- Misaligned word store, addr 0x102, wdata 0x11223344 → first access 0x100, be 1100, wdata 0x33441122; second access 0x104, be 0011, wdata 0x33441122.
- Misaligned word load, addr 0x101, rdata 0xAABBCCDD then 0x11223344 → `lsu_rdata_o` 0x44AABBCC.
- `data_gnt_i` held low 3 cycles → `data_req_o` and the address stay stable for 4 cycles.
- Error path: `data_err_i` on the first response of misaligned 0x101 → no second request, `lsu_err_o` 1.
- Reset mid-operation: `rst_i` pulsed in RVAL1 → outputs 0, `lsu_ready_o` 1, and a late rvalid produces no pulse.
